// File: rtl/charis_pkg.sv
// ---------------------------------------------------------------------------
// charis_pkg : opcode/func/ALU encodings and FSM state encoding for charis
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package charis_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b010000;
  localparam logic [5:0] OP_BNE   = 6'b010001;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_SW    = 6'b011111;

  localparam logic [5:0] FN_ADD = 6'b110000;
  localparam logic [5:0] FN_SUB = 6'b110001;
  localparam logic [5:0] FN_AND = 6'b110010;
  localparam logic [5:0] FN_OR  = 6'b110011;
  localparam logic [5:0] FN_NOT = 6'b110100;
  localparam logic [5:0] FN_SRA = 6'b111000;
  localparam logic [5:0] FN_SRL = 6'b111001;
  localparam logic [5:0] FN_SLL = 6'b111010;
  localparam logic [5:0] FN_ROL = 6'b111100;
  localparam logic [5:0] FN_ROR = 6'b111101;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_NOT = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SLL = 4'b1010;
  localparam logic [3:0] ALU_ROL = 4'b1100;
  localparam logic [3:0] ALU_ROR = 4'b1101;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_BRANCH = 3'd5;

  typedef enum logic [2:0] {
    S_FETCH  = ST_FETCH,
    S_DECODE = ST_DECODE,
    S_EXEC   = ST_EXEC,
    S_MEM    = ST_MEM,
    S_WB     = ST_WB,
    S_BRANCH = ST_BRANCH
  } state_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LB);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SB);
  endfunction

  function automatic logic is_byte(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_SB);
  endfunction

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_B) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic is_imm(input logic [5:0] op);
    return (op == OP_LI) || (op == OP_LUI) || (op == OP_ADDI) ||
           (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

`default_nettype wire

// File: rtl/charis_alu_decode.sv
// ---------------------------------------------------------------------------
// charis_alu_decode : (opcode, func) -> ALU operation and legality flag
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module charis_alu_decode
  import charis_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output logic [3:0] alu_func,
  output logic       legal
);

  always_comb begin
    alu_func = ALU_ADD;
    legal    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        legal = 1'b1;
        case (func)
          FN_ADD:  alu_func = ALU_ADD;
          FN_SUB:  alu_func = ALU_SUB;
          FN_AND:  alu_func = ALU_AND;
          FN_OR:   alu_func = ALU_OR;
          FN_NOT:  alu_func = ALU_NOT;
          FN_SRA:  alu_func = ALU_SRA;
          FN_SRL:  alu_func = ALU_SRL;
          FN_SLL:  alu_func = ALU_SLL;
          FN_ROL:  alu_func = ALU_ROL;
          FN_ROR:  alu_func = ALU_ROR;
          default: legal    = 1'b0;
        endcase
      end
      // li/lui rely on the immediate extender; the ALU just adds it to r0
      OP_LI, OP_LUI, OP_ADDI,
      OP_LB, OP_LW, OP_SB, OP_SW: begin
        alu_func = ALU_ADD;
        legal    = 1'b1;
      end
      OP_ANDI: begin
        alu_func = ALU_AND;
        legal    = 1'b1;
      end
      OP_ORI: begin
        alu_func = ALU_OR;
        legal    = 1'b1;
      end
      OP_B, OP_BEQ, OP_BNE: begin
        alu_func = ALU_SUB;
        legal    = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/charis_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// charis_ctrl_fsm : multicycle control FSM with instruction register
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module charis_ctrl_fsm
  import charis_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      Instr,
  input  logic             ALU_zero,
  output logic             PC_sel,
  output logic             PC_LdEn,
  output logic             RF_WrEn,
  output logic             RF_WrData_sel,
  output logic             RF_B_sel,
  output logic             ALU_Bin_sel,
  output logic [3:0]       ALU_func,
  output logic             MEM_WrEn,
  output logic             ByteOp,
  output logic             Illegal,
  output logic [CNT_W-1:0] RetireCnt
);

  state_t           r_state;
  state_t           w_next_state;
  logic [31:0]      r_ir;
  logic [CNT_W-1:0] r_retire_cnt;
  logic [5:0]       w_opcode;
  logic [5:0]       w_func;
  logic [3:0]       w_alu_func;
  logic             w_legal;
  logic             w_ir_unused;

  assign w_opcode    = r_ir[31:26];
  assign w_func      = r_ir[5:0];
  assign w_ir_unused = ^r_ir[25:6];
  assign RetireCnt   = r_retire_cnt;

  charis_alu_decode u_alu_decode (
    .opcode   (w_opcode),
    .func     (w_func),
    .alu_func (w_alu_func),
    .legal    (w_legal)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state      <= S_FETCH;
      r_ir         <= '0;
      r_retire_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_FETCH) begin
        r_ir <= Instr;
      end
      if (PC_LdEn) begin
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_next_state  = r_state;
    PC_sel        = 1'b0;
    PC_LdEn       = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_B_sel      = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = ALU_ADD;
    MEM_WrEn      = 1'b0;
    ByteOp        = 1'b0;
    Illegal       = 1'b0;
    case (r_state)
      S_FETCH: w_next_state = S_DECODE;
      S_DECODE: begin
        // unknown encodings are skipped but still retire to keep the PC moving
        if (!w_legal) begin
          Illegal      = 1'b1;
          PC_LdEn      = 1'b1;
          w_next_state = S_FETCH;
        end else if (is_branch(w_opcode)) begin
          w_next_state = S_BRANCH;
        end else begin
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        ALU_func     = w_alu_func;
        ALU_Bin_sel  = is_imm(w_opcode) || is_load(w_opcode) || is_store(w_opcode);
        w_next_state = (is_load(w_opcode) || is_store(w_opcode)) ? S_MEM : S_WB;
      end
      S_MEM: begin
        ByteOp = is_byte(w_opcode);
        if (is_store(w_opcode)) begin
          MEM_WrEn     = 1'b1;
          RF_B_sel     = 1'b1;
          PC_LdEn      = 1'b1;
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_WB;
        end
      end
      S_WB: begin
        RF_WrEn       = 1'b1;
        PC_LdEn       = 1'b1;
        RF_WrData_sel = is_load(w_opcode);
        ByteOp        = is_byte(w_opcode);
        w_next_state  = S_FETCH;
      end
      S_BRANCH: begin
        ALU_func     = w_alu_func;
        RF_B_sel     = 1'b1;
        PC_LdEn      = 1'b1;
        w_next_state = S_FETCH;
        case (w_opcode)
          OP_BEQ:  PC_sel = ALU_zero;
          OP_BNE:  PC_sel = !ALU_zero;
          default: PC_sel = 1'b1;
        endcase
      end
      default: w_next_state = S_FETCH;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_charis_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_charis_ctrl_fsm : directed table-driven bench for charis_ctrl_fsm
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_charis_ctrl_fsm;

  localparam int CNT_W = 4;
  localparam int NVEC  = 19;

  logic             Clk = 1'b0;
  logic             Reset;
  logic [31:0]      Instr;
  logic             ALU_zero;
  logic             PC_sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel;
  logic             ALU_Bin_sel, MEM_WrEn, ByteOp, Illegal;
  logic [3:0]       ALU_func;
  logic [CNT_W-1:0] RetireCnt;

  int checks   = 0;
  int failures = 0;
  logic [CNT_W-1:0] exp_cnt;

  typedef struct packed {
    logic [31:0] instr;
    logic        zero;
    logic [2:0]  lat;
    logic        pc_sel, rf_wr, wd_sel, mem_wr, ill, byte_op, b_sel, bin_sel;
    logic [3:0]  alu;
  } vec_t;

  vec_t vecs [NVEC];

  charis_ctrl_fsm #(.CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .Instr(Instr), .ALU_zero(ALU_zero),
    .PC_sel(PC_sel), .PC_LdEn(PC_LdEn), .RF_WrEn(RF_WrEn),
    .RF_WrData_sel(RF_WrData_sel), .RF_B_sel(RF_B_sel),
    .ALU_Bin_sel(ALU_Bin_sel), .ALU_func(ALU_func), .MEM_WrEn(MEM_WrEn),
    .ByteOp(ByteOp), .Illegal(Illegal), .RetireCnt(RetireCnt)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
    return {op, 5'd3, 5'd4, 5'd5, 5'd0, fn};
  endfunction

  function automatic vec_t mv(input logic [31:0] ins, input logic z, input logic [2:0] lat,
                              input logic pcs, input logic rfw, input logic wds,
                              input logic mw, input logic il, input logic bo,
                              input logic bs, input logic bin, input logic [3:0] alu);
    vec_t v;
    v = '{ins, z, lat, pcs, rfw, wds, mw, il, bo, bs, bin, alu};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    Instr    = v.instr;
    ALU_zero = v.zero;
    for (int c = 1; c <= int'(v.lat); c++) begin
      @(negedge Clk);
      if (c == int'(v.lat)) begin
        chk($sformatf("v%0d_retire", idx),
            {24'd0, PC_LdEn, PC_sel, RF_WrEn, RF_WrData_sel, MEM_WrEn, Illegal, ByteOp, RF_B_sel},
            {24'd0, 1'b1, v.pc_sel, v.rf_wr, v.wd_sel, v.mem_wr, v.ill, v.byte_op, v.b_sel});
      end else begin
        chk($sformatf("v%0d_idle_c%0d", idx, c),
            {28'd0, PC_LdEn, RF_WrEn, MEM_WrEn, Illegal}, 32'd0);
      end
      if (c == 3) begin
        chk($sformatf("v%0d_alu", idx), {27'd0, ALU_func, ALU_Bin_sel}, {27'd0, v.alu, v.bin_sel});
      end
      @(posedge Clk);
      #1;
      Instr = $urandom;
    end
    exp_cnt = exp_cnt + 1'b1;
    chk($sformatf("v%0d_retire_cnt", idx), {28'd0, RetireCnt}, {28'd0, exp_cnt});
  endtask

  initial begin
    Reset    = 1'b0;
    Instr    = 32'd0;
    ALU_zero = 1'b0;

    //             instr                       z  lat pcs rfw wds mw ill bo bs bin alu
    vecs[0]  = mv(mk(6'b100000, 6'b110000), 0, 4, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0000); // add
    vecs[1]  = mv(mk(6'b100000, 6'b110001), 1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0001); // sub
    vecs[2]  = mv(mk(6'b100000, 6'b111010), 0, 4, 0, 1, 0, 0, 0, 0, 0, 0, 4'b1010); // sll
    vecs[3]  = mv(mk(6'b100000, 6'b111101), 1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 4'b1101); // ror
    vecs[4]  = mv(mk(6'b110011, 6'b101010), 0, 4, 0, 1, 0, 0, 0, 0, 0, 1, 4'b0011); // ori
    vecs[5]  = mv(mk(6'b110010, 6'b000111), 1, 4, 0, 1, 0, 0, 0, 0, 0, 1, 4'b0010); // andi
    vecs[6]  = mv(mk(6'b111000, 6'b000001), 0, 4, 0, 1, 0, 0, 0, 0, 0, 1, 4'b0000); // li
    vecs[7]  = mv(mk(6'b001111, 6'b000100), 0, 5, 0, 1, 1, 0, 0, 0, 0, 1, 4'b0000); // lw
    vecs[8]  = mv(mk(6'b000011, 6'b000100), 1, 5, 0, 1, 1, 0, 0, 1, 0, 1, 4'b0000); // lb
    vecs[9]  = mv(mk(6'b011111, 6'b000100), 0, 4, 0, 0, 0, 1, 0, 0, 1, 1, 4'b0000); // sw
    vecs[10] = mv(mk(6'b000111, 6'b000100), 1, 4, 0, 0, 0, 1, 0, 1, 1, 1, 4'b0000); // sb
    vecs[11] = mv(mk(6'b010000, 6'b000010), 1, 3, 1, 0, 0, 0, 0, 0, 1, 0, 4'b0001); // beq z=1
    vecs[12] = mv(mk(6'b010000, 6'b000010), 0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0001); // beq z=0
    vecs[13] = mv(mk(6'b010001, 6'b000010), 1, 3, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0001); // bne z=1
    vecs[14] = mv(mk(6'b010001, 6'b000010), 0, 3, 1, 0, 0, 0, 0, 0, 1, 0, 4'b0001); // bne z=0
    vecs[15] = mv(mk(6'b111111, 6'b000010), 0, 3, 1, 0, 0, 0, 0, 0, 1, 0, 4'b0001); // b
    vecs[16] = mv(mk(6'b010101, 6'b110000), 0, 2, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000); // illegal op
    vecs[17] = mv(mk(6'b100000, 6'b000000), 1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000); // bad func
    vecs[18] = mv(mk(6'b110000, 6'b000011), 1, 4, 0, 1, 0, 0, 0, 0, 0, 1, 4'b0000); // addi

    repeat (2) @(posedge Clk);
    #1;
    chk("reset_outputs",
        {23'd0, PC_sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel, MEM_WrEn, ByteOp, Illegal},
        32'd0);
    chk("reset_cnt", {28'd0, RetireCnt}, 32'd0);

    // Reset pulled low in the middle of an add's writeback
    Reset = 1'b1;
    Instr = mk(6'b100000, 6'b110000);
    for (int c = 1; c <= 3; c++) begin
      @(negedge Clk);
      chk($sformatf("midwb_idle_c%0d", c), {28'd0, PC_LdEn, RF_WrEn, MEM_WrEn, Illegal}, 32'd0);
      @(posedge Clk);
      #1;
      Instr = $urandom;
    end
    @(negedge Clk);
    chk("midwb_active", {30'd0, RF_WrEn, PC_LdEn}, 32'd3);
    #1 Reset = 1'b0;
    #1;
    chk("midwb_drop", {28'd0, RF_WrEn, PC_LdEn, MEM_WrEn, Illegal}, 32'd0);
    @(posedge Clk);
    #1 Reset = 1'b1;
    chk("midwb_cnt", {28'd0, RetireCnt}, 32'd0);

    exp_cnt = '0;
    for (int i = 0; i < NVEC; i++) begin
      run_vec(i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
